// File: rtl/fnd_pkg.sv
// Shared types, constants and the hex-to-segment table for the 4-digit
// common-anode FND scan driver.
package fnd_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    // The counter has to hold 0 .. BLANK_CYCLES-1.
    function automatic int blank_cnt_w(input int blank_cycles);
        return $clog2(blank_cycles + 1);
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fnd_hex_decoder.sv
// Purely combinational nibble-to-segment decoder, active low, {dp,g..a};
// the decimal point is always off.
module fnd_hex_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_o
);

    assign seg_o = {1'b1, hex_seg(nibble_i)};

endmodule

// File: rtl/fnd_scan_driver.sv
// 4-digit common-anode FND scan driver with anti-ghosting blanking and a
// frame-synchronous double-buffered display value.
// Optional leading-zero suppression: define FND_LZ_BLANK_EN.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int BLANK_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [1:0]  i_digit_sel,
    input  logic [15:0] i_value,
    input  logic        i_load,
    output logic        o_pending,
    output logic [3:0]  o_an,
    output logic [7:0]  o_seg
);

    localparam int              CNT_W    = blank_cnt_w(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [15:0]       shadow_q, shadow_d;
    logic [15:0]       active_q, active_d;
    logic              pending_q, pending_d;
    logic [3:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    logic [3:0]        nibble;
    logic [7:0]        dec_seg;
    logic [3:0]        drive_an;
    logic [7:0]        drive_seg;
    logic              sel_change;
    logic              frame_wrap;

    assign nibble     = active_q[{sel_q, 2'b00} +: 4];
    assign drive_an   = ~(4'b0001 << sel_q);
    assign sel_change = (i_digit_sel != sel_q);
    assign frame_wrap = (sel_q == 2'd3) && (i_digit_sel == 2'd0);

    fnd_hex_decoder u_dec (
        .nibble_i (nibble),
        .seg_o    (dec_seg)
    );

`ifdef FND_LZ_BLANK_EN
    // A digit above 0 is dark when it and every digit left of it are zero.
    logic lz_blank;
    assign lz_blank  = (sel_q != 2'd0) && ((active_q >> {sel_q, 2'b00}) == 16'h0000);
    assign drive_seg = lz_blank ? SEG_BLANK : dec_seg;
`else
    assign drive_seg = dec_seg;
`endif

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        an_d    = AN_OFF;
        seg_d   = SEG_BLANK;
        if (sel_change) begin
            sel_d   = i_digit_sel;
            state_d = ST_BLANK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DRIVE;
                        an_d    = drive_an;
                        seg_d   = drive_seg;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    an_d  = drive_an;
                    seg_d = drive_seg;
                end
            endcase
        end
    end

    // A load coinciding with the wrap bypasses the shadow so it is not lost.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (frame_wrap) begin
            active_d  = i_load ? i_value : shadow_q;
            pending_d = 1'b0;
            if (i_load) shadow_d = i_value;
        end else if (i_load) begin
            shadow_d  = i_value;
            pending_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // update together from the pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_BLANK;
            cnt_q     <= '0;
            sel_q     <= 2'd0;
            shadow_q  <= 16'h0000;
            active_q  <= 16'h0000;
            pending_q <= 1'b0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign o_an      = an_q;
    assign o_seg     = seg_q;
    assign o_pending = pending_q;

endmodule
